// File: rtl/mem_stage_bus_master_if.sv
// mem_stage_bus_master_if: req/ack data bus between the MEM-stage master and a memory responder
interface mem_stage_bus_master_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  modport master(output req, we, addr, be, wdata, input ack, rdata);
  modport slave(input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage_bus_master.sv
// mem_stage_bus_master: MEM-stage load/store unit driving a req/ack bus, with stall, load extension and error flags
module mem_stage_bus_master #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            InstrM,
  input  logic [31:0]            ALUOutM,
  input  logic [31:0]            WriteDataM,
  input  logic                   InterruptRequest,
  mem_stage_bus_master_if.master bus,
  output logic                   StallM,
  output logic [31:0]            ReadDataM,
  output logic                   AddrErr,
  output logic                   BusErr
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       op;
  logic [1:0]       sz, sz_q, lane_q;
  logic             is_load, is_store, memop, aligned, uns_q, load_q;
  logic [3:0]       be;
  logic [31:0]      wdata, ext;
  logic [7:0]       rb;
  logic [15:0]      rh;
  logic             unused_ok;
  assign unused_ok = ^InstrM[25:0];
  // opcode[1:0] encodes access size (00 byte, 01 half, 11 word), opcode[2] marks unsigned loads
  assign op       = InstrM[31:26];
  assign sz       = op[1:0];
  assign is_load  = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  assign is_store = op inside {6'h28, 6'h29, 6'h2B};
  assign memop    = is_load | is_store;
  assign aligned  = sz == 2'b00 ? 1'b1 : sz == 2'b01 ? !ALUOutM[0] : ALUOutM[1:0] == 2'b00;
  assign be       = sz == 2'b00 ? 4'b0001 << ALUOutM[1:0] :
                    sz == 2'b01 ? (ALUOutM[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata    = sz == 2'b00 ? {4{WriteDataM[7:0]}} :
                    sz == 2'b01 ? {2{WriteDataM[15:0]}} : WriteDataM;
  assign AddrErr  = memop & !aligned;
  assign StallM   = memop & aligned & (state != DONE) & !(state == IDLE & InterruptRequest);
  // lane and size are latched at issue so extraction does not depend on the stalled pipeline inputs
  assign rb       = bus.rdata[{lane_q, 3'b000} +: 8];
  assign rh       = lane_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
  assign ext      = sz_q == 2'b11 ? bus.rdata :
                    sz_q == 2'b01 ? {{16{!uns_q & rh[15]}}, rh} : {{24{!uns_q & rb[7]}}, rb};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= '0;
      bus.be    <= '0;
      bus.wdata <= '0;
      ReadDataM <= '0;
      BusErr    <= 1'b0;
      load_q    <= 1'b0;
      uns_q     <= 1'b0;
      sz_q      <= '0;
      lane_q    <= '0;
    end else begin
      BusErr <= 1'b0;
      case (state)
        IDLE: if (memop && aligned && !InterruptRequest) begin
          state     <= WAIT;
          cnt       <= '0;
          bus.req   <= 1'b1;
          bus.we    <= is_store;
          bus.addr  <= {ALUOutM[31:2], 2'b00};
          bus.be    <= be;
          bus.wdata <= wdata;
          load_q    <= is_load;
          uns_q     <= op[2];
          sz_q      <= sz;
          lane_q    <= ALUOutM[1:0];
        end
        WAIT: if (bus.ack) begin
          bus.req <= 1'b0;
          if (load_q) ReadDataM <= ext;
          state   <= DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          bus.req <= 1'b0;
          if (load_q) ReadDataM <= '0;
          BusErr  <= 1'b1;
          state   <= DONE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_bus_master.sv
// tb_mem_stage_bus_master: directed bench; expected bus transactions and results queue up as stimulus is driven
module tb_mem_stage_bus_master;
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;
  logic        clk = 0, reset = 0, InterruptRequest = 0, StallM, AddrErr, BusErr;
  logic [31:0] InstrM = 0, ALUOutM = 0, WriteDataM = 0, ReadDataM;
  int          tests = 0, fails = 0;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ck_wd;
    logic [31:0] rd;
    logic        berr;
  } exp_t;
  exp_t q[$];
  mem_stage_bus_master_if bus();
  mem_stage_bus_master #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .InstrM(InstrM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .InterruptRequest(InterruptRequest), .bus(bus), .StallM(StallM), .ReadDataM(ReadDataM),
    .AddrErr(AddrErr), .BusErr(BusErr)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one access, plays the responder (ack after ack_after WAIT cycles, -1 = never) and checks the result in DONE.
  task automatic access(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int ack_after, input logic we, input logic [3:0] be,
                        input logic [31:0] wdat, input logic ck_wd, input logic [31:0] exp_rd,
                        input logic berr, input int exp_stalls);
    exp_t cur;
    int   stalls = 0, w = 0, n = 0;
    bit   seen = 0;
    q.push_back('{we, {a[31:2], 2'b00}, be, wdat, ck_wd, exp_rd, berr});
    InstrM = {op, 26'h0}; ALUOutM = a; WriteDataM = wd; bus.rdata = rd; bus.ack = 0;
    #1;
    while (StallM && n < 100) begin
      stalls++;
      if (bus.req && !seen) begin
        seen = 1;
        chk({tag, " sb_depth"}, 32'(q.size()), 1);
        cur = q.pop_front();
        chk({tag, " we"}, 32'(bus.we), 32'(cur.we));
        chk({tag, " addr"}, bus.addr, cur.addr);
        chk({tag, " be"}, 32'(bus.be), 32'(cur.be));
        if (cur.ck_wd) chk({tag, " wdata"}, bus.wdata, cur.wdata);
      end
      if (bus.req) begin
        bus.ack = (w == ack_after);
        w++;
      end
      @(negedge clk); #1;
      n++;
    end
    bus.ack = 0;
    chk({tag, " req_seen"}, 32'(seen), 1);
    chk({tag, " stalls"}, 32'(stalls), 32'(exp_stalls));
    chk({tag, " done_req"}, 32'(bus.req), 0);
    if (seen) begin
      chk({tag, " rdata"}, ReadDataM, cur.rd);
      chk({tag, " buserr"}, 32'(BusErr), 32'(cur.berr));
    end
    InstrM = 0;
    @(negedge clk); #1;
    chk({tag, " buserr_clr"}, 32'(BusErr), 0);
    chk({tag, " idle_stall"}, 32'(StallM), 0);
  endtask

  initial begin
    bus.ack = 0; bus.rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst req", 32'(bus.req), 0);
    chk("rst we", 32'(bus.we), 0);
    chk("rst addr", bus.addr, 0);
    chk("rst be", 32'(bus.be), 0);
    chk("rst wdata", bus.wdata, 0);
    chk("rst rdata", ReadDataM, 0);
    chk("rst buserr", 32'(BusErr), 0);
    reset = 1;
    @(negedge clk); #1;
    access("lw", LW, 32'h100, 0, 32'hDEADBEEF, 0, 0, 4'hF, 0, 0, 32'hDEADBEEF, 0, 2);
    access("lb", LB, 32'h103, 0, 32'h80123456, 0, 0, 4'h8, 0, 0, 32'hFFFFFF80, 0, 2);
    access("lbu", LBU, 32'h103, 0, 32'h80123456, 0, 0, 4'h8, 0, 0, 32'h00000080, 0, 2);
    access("sh", SH, 32'h202, 32'h0000ABCD, 0, 3, 1, 4'hC, 32'hABCDABCD, 1, 32'h00000080, 0, 5);
    access("lh", LH, 32'h102, 0, 32'h80011234, 1, 0, 4'hC, 0, 0, 32'hFFFF8001, 0, 3);
    access("lhu", LHU, 32'h100, 0, 32'h8001F234, 0, 0, 4'h3, 0, 0, 32'h0000F234, 0, 2);
    access("sb", SB, 32'h101, 32'h12345678, 0, 2, 1, 4'h2, 32'h78787878, 1, 32'h0000F234, 0, 4);
    access("sw_to", SW, 32'h300, 32'h11223344, 0, -1, 1, 4'hF, 32'h11223344, 1, 32'h0000F234, 1, 17);
    access("lw_to", LW, 32'h304, 0, 32'hFFFFFFFF, -1, 0, 4'hF, 0, 0, 32'h00000000, 1, 17);
    access("lw2", LW, 32'h500, 0, 32'h5A5A5A5A, 0, 0, 4'hF, 0, 0, 32'h5A5A5A5A, 0, 2);
    // misaligned accesses never reach the bus
    InstrM = {LW, 26'h0}; ALUOutM = 32'h101; #1;
    chk("mis lw adderr", 32'(AddrErr), 1);
    chk("mis lw stall", 32'(StallM), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("mis lw req", 32'(bus.req), 0);
    chk("mis lw rdata", ReadDataM, 32'h5A5A5A5A);
    InstrM = {SH, 26'h0}; ALUOutM = 32'h203; #1;
    chk("mis sh adderr", 32'(AddrErr), 1);
    chk("mis sh stall", 32'(StallM), 0);
    InstrM = {LBU, 26'h0}; #1;
    chk("lbu odd adderr", 32'(AddrErr), 0);
    InstrM = 0;
    @(negedge clk); #1;
    // ack while idle has no effect
    bus.ack = 1; bus.rdata = 32'hCAFEF00D;
    @(negedge clk); #1;
    chk("idle ack req", 32'(bus.req), 0);
    chk("idle ack rdata", ReadDataM, 32'h5A5A5A5A);
    bus.ack = 0;
    // interrupt blocks issue
    InterruptRequest = 1; InstrM = {LW, 26'h0}; ALUOutM = 32'h600; #1;
    chk("irq stall", 32'(StallM), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("irq req", 32'(bus.req), 0);
    InterruptRequest = 0; InstrM = 0;
    @(negedge clk); #1;
    // interrupt ignored in WAIT, then async reset mid-WAIT
    InstrM = {LW, 26'h0}; ALUOutM = 32'h700;
    @(negedge clk); #1;
    chk("wait req", 32'(bus.req), 1);
    InterruptRequest = 1; #1;
    chk("wait irq stall", 32'(StallM), 1);
    @(negedge clk); #1;
    chk("wait irq req", 32'(bus.req), 1);
    #1 reset = 0;
    #1;
    chk("arst req", 32'(bus.req), 0);
    chk("arst rdata", ReadDataM, 0);
    chk("arst idle", 32'(StallM), 0);
    InterruptRequest = 0; InstrM = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk); #1;
    access("lw_post", LW, 32'h800, 0, 32'h01234567, 0, 0, 4'hF, 0, 0, 32'h01234567, 0, 2);
    chk("sb_left", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_stage_bus_master.md
Name: mem_stage_bus_master

Overview:
- Memory-stage access unit. Consumes the EX/MEM pipeline register outputs (InstrM, ALUOutM, WriteDataM) and turns load/store instructions into transactions on the external data bus.
- Uses a req/ack handshake on that bus and stalls the pipeline until each access completes.
- Returns sign- or zero-extended load data for the MEM/WB register and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 16, max cycles in WAIT without bus_ack before a bus error is declared.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- InstrM  input  32  instruction in MEM stage
- ALUOutM  input  32  effective byte address
- WriteDataM  input  32  store data (rt value)
- InterruptRequest  input  1  pending interrupt; blocks issue of new accesses
- bus_req  output  1  transaction request, registered
- bus_we  output  1  1 = write, registered
- bus_addr  output  32  word address, {ALUOutM[31:2],2'b00}, registered
- bus_be  output  4  byte enables, bit i = byte lane i (little-endian), registered
- bus_wdata  output  32  write data, lane-replicated, registered
- bus_ack  input  1  responder completion, sampled on rising clk
- bus_rdata  input  32  read word, valid when bus_ack=1
- StallM  output  1  combinational; freezes IF..EX/MEM while high
- ReadDataM  output  32  extended load result, registered
- AddrErr  output  1  combinational misalignment flag for the current InstrM
- BusErr  output  1  one-cycle pulse on timeout, registered

Behaviour:
- Decode on InstrM[31:26]:
  - lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25 are loads.
  - sb 0x28, sh 0x29, sw 0x2B are stores.
  - Every other opcode is non-memory.
- Misalignment: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0.
  - AddrErr=1, no bus access, StallM=0, ReadDataM is not updated.
- States:
  - IDLE, WAIT, DONE.
  - Reset (reset=0, async): state=IDLE. bus_req, bus_we, bus_addr, bus_be, bus_wdata, ReadDataM, BusErr and the counter all clear to 0.
- IDLE:
  - If the opcode is a memory op, is aligned, and InterruptRequest=0: on the next edge load bus_* and set bus_req=1, counter=0, state=WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - bus_ack=1 at an edge: bus_req<=0. For loads, ReadDataM<=extended data. state<=DONE.
  - Else if counter==TIMEOUT-1: bus_req<=0, ReadDataM<=0, BusErr<=1 for one cycle, state<=DONE.
  - Else counter increments.
  - InterruptRequest is ignored in WAIT; a started transaction is never aborted.
- DONE: StallM=0 for exactly one cycle, so the pipeline advances on this edge. Next state is IDLE.
- StallM = memop && aligned && (state!=DONE) && !(state==IDLE && InterruptRequest).
- Latency: ack in the first WAIT cycle gives 2 stall cycles; each extra wait cycle adds 1.
- Byte enables and write data:
  - sb: be = 4'b0001<<addr[1:0], wdata = {4{WriteDataM[7:0]}}.
  - sh: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{WriteDataM[15:0]}}.
  - sw: be = 4'b1111, wdata = WriteDataM.
  - Loads: be is set to the same lane pattern, bus_we=0.
- Load extraction:
  - Byte lane addr[1:0], halfword lane addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- bus_ack outside WAIT is ignored.
- A reset during WAIT drops bus_req immediately (async) and returns to IDLE.

Test Plan:
- lw addr 0x100, bus_ack in first WAIT cycle, rdata 0xDEADBEEF -> bus_req high 1 cycle, addr 0x100, be 1111, StallM high 2 cycles, ReadDataM=0xDEADBEEF in DONE.
- lb addr 0x103, rdata 0x80123456 -> be 1000, ReadDataM=0xFFFFFF80. Same case with lbu -> ReadDataM=0x00000080.
- sh addr 0x202, WriteDataM 0x0000ABCD, ack after 3 wait cycles -> bus_we=1, be 1100, wdata 0xABCDABCD, StallM high 5 cycles.
- lw addr 0x101 -> AddrErr=1, bus_req never asserts, StallM=0.
- sw with no ack, TIMEOUT=16 -> BusErr pulses once after 16 WAIT cycles, then DONE, then IDLE. ReadDataM unchanged.
- InterruptRequest=1 in IDLE with lw pending -> no request issued, StallM=0. Separately, reset driven low mid-WAIT -> bus_req=0 and state=IDLE without waiting for a clock edge.
